// File: rtl/scan_pkg.sv
// scan_pkg: shared types and default parameters for the scan-chain master.
package scan_pkg;
  localparam int ScanLenDef = 64;
  localparam int ClkDivDef = 2;
  localparam int GapCyclesDef = 1;
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_UPDATE, ST_RESET, ST_DONE} scan_drv_state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_P, PH_HOLD, PH_N} scan_phase_e;
  typedef struct packed {
    logic sclkp;
    logic sclkn;
    logic senable;
    logic supdate;
    logic sreset;
  } scan_ctrl_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/scan_if.sv
// scan_if: serial data plus control strobes between scan master and chain.
interface scan_if;
  import scan_pkg::*;
  logic sdata;
  scan_ctrl_t sctrl;
  modport send (output sdata, sctrl);
  modport recv (input sdata, sctrl);
endinterface

// File: rtl/scan_phase_gen.sv
// scan_phase_gen: sequences SETUP/P/HOLD/N sub-phases of one scan bit while enabled.
module scan_phase_gen import scan_pkg::*; #(
  parameter int ClkDiv = ClkDivDef,
  parameter int GapCycles = GapCyclesDef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output scan_phase_e phase,
  output logic        phase_last,
  output logic        bit_done
);
  localparam int CW = $clog2(max2(ClkDiv, GapCycles) + 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_m1;
  logic [1:0] phase_inc;
  assign len_m1 = (phase == PH_P || phase == PH_N) ? CW'(ClkDiv - 1) : CW'(GapCycles - 1);
  assign phase_last = cnt == len_m1;
  assign bit_done = en && phase == PH_N && phase_last;
  assign phase_inc = phase + 2'd1;
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase <= PH_SETUP;
      cnt <= '0;
    end else if (phase_last) begin
      phase <= scan_phase_e'(phase_inc);
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/scan_driver.sv
// scan_driver: serializes a config word onto a scan chain, then updates; optional readback via SCAN_DRIVER_READBACK_EN.
module scan_driver import scan_pkg::*; #(
  parameter int ScanLen = ScanLenDef,
  parameter int ClkDiv = ClkDivDef,
  parameter int GapCycles = GapCyclesDef
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [ScanLen-1:0] wdata,
  input  logic               reset_req,
  input  logic               scan_in,
  output logic               busy,
  output logic               done,
  output logic [ScanLen-1:0] rdata,
  output logic               rdata_valid,
  scan_if.send               scan
);
  localparam int BW = $clog2(ScanLen + 1);
  localparam int CW = $clog2(max2(ClkDiv, GapCycles) + 1);
  scan_drv_state_e state, state_n;
  scan_phase_e phase;
  logic phase_last, bit_done, load;
  logic [ScanLen-1:0] sr;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] rcnt;
  scan_phase_gen #(.ClkDiv(ClkDiv), .GapCycles(GapCycles)) u_phase (
    .clk(clk),
    .rst(rst),
    .en(state == ST_SHIFT || state == ST_UPDATE),
    .phase(phase),
    .phase_last(phase_last),
    .bit_done(bit_done)
  );
  always_comb begin
    state_n = state;
    load = 1'b0;
    case (state)
      ST_IDLE: begin
        state_n = reset_req ? ST_RESET : start_valid ? ST_SHIFT : ST_IDLE;
        load = !reset_req && start_valid;
      end
      ST_SHIFT:  state_n = (bit_done && bcnt == BW'(ScanLen - 1)) ? ST_UPDATE : ST_SHIFT;
      ST_UPDATE: state_n = (phase == PH_P && phase_last) ? ST_DONE : ST_UPDATE;
      ST_RESET:  state_n = (rcnt == CW'(ClkDiv - 1)) ? ST_DONE : ST_RESET;
      default:   state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sr <= '0;
      bcnt <= '0;
      rcnt <= '0;
    end else begin
      state <= state_n;
      sr <= load ? wdata : bit_done ? {sr[ScanLen-2:0], 1'b0} : sr;
      bcnt <= load ? '0 : bit_done ? bcnt + BW'(1) : bcnt;
      rcnt <= state == ST_RESET ? rcnt + CW'(1) : '0;
    end
  end
  assign start_ready = state == ST_IDLE && !rst;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  // Scan strobes decode only from flops so no input reaches the chain combinationally.
  assign scan.sdata = state == ST_SHIFT && sr[ScanLen-1];
  assign scan.sctrl = '{
    sclkp:   state == ST_SHIFT && phase == PH_P,
    sclkn:   state == ST_SHIFT && phase == PH_N,
    senable: state == ST_SHIFT,
    supdate: state == ST_UPDATE && phase == PH_P,
    sreset:  state == ST_RESET
  };
`ifdef SCAN_DRIVER_READBACK_EN
  logic [ScanLen-1:0] cap;
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
    end else begin
      if (bit_done) cap <= {cap[ScanLen-2:0], scan_in};
      if (state == ST_UPDATE && state_n == ST_DONE) rdata <= cap;
      rdata_valid <= state == ST_UPDATE && state_n == ST_DONE;
    end
  end
`else
  logic unused_scan_in;
  assign unused_scan_in = scan_in;
  assign rdata = '0;
  assign rdata_valid = 1'b0;
`endif
endmodule

// File: tb/tb_scan_driver.sv
// tb_scan_driver: directed bench with a bit scoreboard for scan_driver (ScanLen=8, ClkDiv=2, GapCycles=1).
module tb_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic reset_req = 1'b0;
  logic [7:0] wdata = '0;
  logic start_ready, busy, done, rdata_valid, scan_in;
  logic [7:0] rdata;
  logic [7:0] chain = 8'h5A;
  logic lat_bit = 1'b0;
  scan_if sif();
  scan_driver #(.ScanLen(8), .ClkDiv(2), .GapCycles(1)) dut (
    .clk(clk),
    .rst(rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .wdata(wdata),
    .reset_req(reset_req),
    .scan_in(scan_in),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .rdata_valid(rdata_valid),
    .scan(sif)
  );
  always #5 clk = ~clk;
  // Model chain: cell captures sdata on sclkp, shifts on sclkn falling; last cell feeds back.
  assign scan_in = chain[7];
  always @(posedge sif.sctrl.sclkp) lat_bit <= sif.sdata;
  always @(negedge sif.sctrl.sclkn) chain <= {chain[6:0], lat_bit};
  int errors = 0;
  int checks = 0;
  int p_rise, n_rise, en_cyc, upd_cyc, rst_cyc, p_w, n_w;
  logic pp = 1'b0, pn = 1'b0, psd = 1'b0;
  logic [7:0] exp_rb;
  logic exp_q[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic p, n;
    @(posedge clk);
    #1;
    p = sif.sctrl.sclkp;
    n = sif.sctrl.sclkn;
    chk("overlap", p & n, 0);
    if ((p && pp) || (n && pn)) chk("sdata_stable", sif.sdata, psd);
    if (p && !pp) begin
      p_rise++;
      if (exp_q.size() > 0) chk("sdata_bit", sif.sdata, exp_q.pop_front());
    end
    if (n && !pn) n_rise++;
    if (!p && pp && !rst) chk("sclkp_w", p_w, 2);
    if (!n && pn && !rst) chk("sclkn_w", n_w, 2);
    p_w = p ? p_w + 1 : 0;
    n_w = n ? n_w + 1 : 0;
    en_cyc += int'(sif.sctrl.senable);
    upd_cyc += int'(sif.sctrl.supdate);
    rst_cyc += int'(sif.sctrl.sreset);
    pp = p;
    pn = n;
    psd = sif.sdata;
  endtask
  task automatic clr_counts();
    p_rise = 0; n_rise = 0; en_cyc = 0; upd_cyc = 0; rst_cyc = 0;
  endtask
  task automatic accept(input logic [7:0] w);
    int k = 0;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    wdata = w;
    start_valid = 1'b1;
    exp_rb = chain;
    while (!start_ready && k < 20) begin
      tick();
      k++;
    end
    chk("accept_ready", start_ready, 1);
    clr_counts();
    tick();
    start_valid = 1'b0;
  endtask
  task automatic finish_shift(input logic [7:0] w, input bit intrude);
    int lat = 0;
    chk("senable_first", sif.sctrl.senable, 1);
    while (!done && lat < 200) begin
      if (intrude && lat == 10) begin start_valid = 1'b1; wdata = ~w; end
      if (intrude && lat == 20) begin start_valid = 1'b0; wdata = w; end
      tick();
      lat++;
      if (intrude && lat > 10 && lat <= 20) chk("ready_while_busy", start_ready, 0);
    end
    chk("done_lat", lat, 51);
    chk("sclkp_count", p_rise, 8);
    chk("sclkn_count", n_rise, 8);
    chk("senable_cycles", en_cyc, 48);
    chk("supdate_cycles", upd_cyc, 2);
    chk("sb_empty", exp_q.size(), 0);
`ifdef SCAN_DRIVER_READBACK_EN
    chk("rdata", rdata, exp_rb);
    chk("rdata_valid", rdata_valid, 1);
`else
    chk("rdata", rdata, 0);
    chk("rdata_valid", rdata_valid, 0);
`endif
    tick();
    chk("done_pulse", done, 0);
    chk("rdata_valid_pulse", rdata_valid, 0);
  endtask
  initial begin
    int nd;
    p_w = 0; n_w = 0;
    clr_counts();
    tick();
    tick();
    chk("rst_ready", start_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_sdata", sif.sdata, 0);
    chk("rst_sctrl", sif.sctrl, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", start_ready, 1);
    chk("idle_busy", busy, 0);
    accept(8'hA5);
    finish_shift(8'hA5, 1'b0);
    clr_counts();
    reset_req = 1'b1;
    start_valid = 1'b1;
    wdata = 8'hC3;
    tick();
    reset_req = 1'b0;
    chk("sreset_c0", sif.sctrl.sreset, 1);
    chk("ready_in_reset", start_ready, 0);
    chk("busy_in_reset", busy, 1);
    tick();
    chk("sreset_c1", sif.sctrl.sreset, 1);
    chk("done_early", done, 0);
    tick();
    chk("reset_done", done, 1);
    chk("reset_rvalid", rdata_valid, 0);
    chk("sreset_cycles", rst_cyc, 2);
    chk("no_shift_in_reset", p_rise, 0);
    tick();
    chk("ready_after_reset", start_ready, 1);
    accept(8'hC3);
    finish_shift(8'hC3, 1'b0);
    accept(8'h96);
    finish_shift(8'h96, 1'b1);
    accept(8'hA5);
    nd = 0;
    while (p_rise < 4 && nd < 100) begin
      tick();
      nd++;
    end
    chk("reach_bit4", p_rise, 4);
    rst = 1'b1;
    tick();
    chk("midrst_sdata", sif.sdata, 0);
    chk("midrst_sctrl", sif.sctrl, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", start_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      nd += int'(done);
    end
    chk("no_done_after_rst", nd, 0);
    chk("midrst_idle_ready", start_ready, 1);
    accept(8'h3C);
    finish_shift(8'h3C, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_driver.md
# scan_driver

Scan-chain master that drives the `send` end of the `scan_if` bundle from the digital backend's system clock. It accepts a parallel configuration word from the host-side register logic through a valid/ready handshake. It serializes the word onto `sdata` with two non-overlapping scan clock phases (`sclkp`/`sclkn`), then pulses `supdate` to latch the chain. It also issues standalone `sreset` pulses and optionally captures the chain's serial return for readback.

## Interface
Parameters:
- `ScanLen`, 64: chain length in bits; ≥ 2.
- `ClkDiv`, 2: cycles each scan clock phase (or `supdate`/`sreset`) stays high; ≥ 1.
- `GapCycles`, 1: non-overlap/setup cycles with both phases low; ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  request to shift `wdata` and then update.
- `start_ready`  out  1  high only in IDLE.
- `wdata`  in  ScanLen  word to load into the chain; captured on handshake.
- `reset_req`  in  1  request a chain reset pulse; sampled in IDLE only.
- `scan_in`  in  1  serial return from the chain's last cell.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a shift+update or a reset sequence completes.
- `rdata`  out  ScanLen  captured readback word.
- `rdata_valid`  out  1  one-cycle pulse, coincident with `done` after a shift.
- `scan`  modport  `scan_if.send`  drives `sdata` and `sctrl` {`sclkp`, `sclkn`, `senable`, `supdate`, `sreset`}.

## Operation
- States: IDLE, SHIFT, UPDATE, RESET, DONE.
- IDLE:
  - `reset_req`=1 → RESET. This has priority over `start_valid` in the same cycle.
  - Otherwise `start_valid && start_ready` → latch `wdata` into the shift register, clear the bit counter, go to SHIFT.
- SHIFT: each bit runs four sub-phases in order:
  - SETUP: `GapCycles` cycles, `sdata` driven, both clocks low.
  - P: `ClkDiv` cycles, `sclkp`=1.
  - HOLD: `GapCycles` cycles, both clocks low.
  - N: `ClkDiv` cycles, `sclkn`=1.
- SHIFT details:
  - `senable`=1 for the whole state.
  - `sdata` = MSB of the shift register; the word goes out MSB first, so `wdata[0]` is shifted last.
  - The shift register advances one bit at the end of N.
  - After `ScanLen` bits → UPDATE.
- UPDATE: `GapCycles` cycles with all controls low, then `supdate`=1 for `ClkDiv` cycles → DONE.
- RESET: `sreset`=1 for `ClkDiv` cycles, all other controls low → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `sclkp` and `sclkn` are never high in the same cycle. `sdata` never changes while either phase is high.
- `wdata` and `start_valid` are ignored while busy; there is no queueing.
- Bit counter width is `$clog2(ScanLen+1)`. The sub-phase counter width is `$clog2(max(ClkDiv,GapCycles)+1)`.

## Timing
- Reset values:
  - `start_ready`=0 during the `rst` cycle, 1 afterwards (IDLE).
  - `busy`=0, `done`=0, `rdata`='0, `rdata_valid`=0.
  - `sdata`=0, `sclkp`=`sclkn`=`senable`=`supdate`=`sreset`=0.
- All scan outputs are registered: no combinational path from inputs to `scan`.
- Bit period = 2·(ClkDiv+GapCycles) cycles.
- `done` asserts ScanLen·2·(ClkDiv+GapCycles) + GapCycles + ClkDiv cycles after the cycle in which the handshake is accepted.
- Reset sequence: `done` asserts `ClkDiv` cycles after `reset_req` is sampled.
- `rst` mid-sequence: the block returns to IDLE on the next edge and all scan controls drop to 0 in the same cycle. No `done` is issued and the partial chain state is not updated.

## Configuration
- Macro `SCAN_DRIVER_READBACK_EN`.
- Defined:
  - `scan_in` is sampled in the last cycle of each N phase and shifted into a capture register, first sample landing at bit ScanLen-1.
  - `rdata` is loaded from the capture register in DONE.
  - `rdata_valid` pulses with `done` after a shift sequence, not after a reset sequence.
- Undefined:
  - No capture register.
  - `rdata`='0 and `rdata_valid`=0 constantly; `scan_in` is unused.

## Structure
- Package `scan_pkg`:
  - `scan_drv_state_e` state enum.
  - `scan_phase_e` sub-phase enum (SETUP/P/HOLD/N).
  - Default-parameter constants.
- Sub-module `scan_phase_gen`:
  - Sub-phase counter and sequencer.
  - Outputs `phase`, `phase_last`, `bit_done`.
  - The top FSM consumes `bit_done`.

## Test plan
Use ScanLen=8, ClkDiv=2, GapCycles=1.
- `wdata`=8'hA5, `start_valid` pulse → `sdata` sequence 1,0,1,0,0,1,0,1 sampled on `sclkp`; 8 `sclkp` and 8 `sclkn` pulses, each 2 cycles; `supdate` high for 2 cycles; `done` 51 cycles after acceptance.
- Assertions on every cycle → never `sclkp`&`sclkn`; `sdata` stable while either phase is high; `senable` high exactly across SHIFT.
- `reset_req` and `start_valid` both high in IDLE → `sreset` high for 2 cycles, no shift, `done` 2 cycles later; start is then accepted on the next IDLE cycle.
- `start_valid` during SHIFT with a different `wdata` → ignored; `start_ready`=0; the original word completes.
- `rst` asserted at bit 4 → next cycle all scan outputs 0, `busy`=0, no `done`; a fresh 8'h3C shift then completes normally.
- With `SCAN_DRIVER_READBACK_EN`, `scan_in` fed as an 8-cycle-delayed model chain preloaded 8'h5A → `rdata`=8'h5A with `rdata_valid` on the `done` cycle. Without the macro → `rdata`=0 throughout.
